// File: rtl/mru_stack_if.sv
// Access/result bundle for the tick-paced MRU list.
// The master drives pacing, flush and requests; the slave is the list itself.
interface mru_stack_if #(
    parameter int DEPTH = 4,
    parameter int KEY_W = 4
);
    logic                         tick;
    logic                         flush;
    logic                         req_valid;
    logic [KEY_W-1:0]             req_key;
    logic                         req_ready;
    logic                         done;
    logic                         hit;
    logic [$clog2(DEPTH)-1:0]     hit_pos;
    logic                         evicted;
    logic [KEY_W-1:0]             evict_key;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic [DEPTH*KEY_W-1:0]       list_flat;

    modport master (
        output tick, flush, req_valid, req_key,
        input  req_ready, done, hit, hit_pos, evicted, evict_key, count, list_flat
    );

    modport slave (
        input  tick, flush, req_valid, req_key,
        output req_ready, done, hit, hit_pos, evicted, evict_key, count, list_flat
    );
endinterface

// File: rtl/mru_stack.sv
// Tick-paced most-recently-used list. Each accepted access takes three
// cycles (accept, compare, update) and finishes with a one-cycle done pulse.
// Entry 0 is the MRU slot; a miss on a full list evicts the last entry.
module mru_stack #(
    parameter int DEPTH = 4,
    parameter int KEY_W = 4
) (
    input logic         clk,
    input logic         rst,
    mru_stack_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        UPD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;

    logic [KEY_W-1:0] key_q;
    logic [PW-1:0]    pos_q;
    logic             match_q;
    logic [PW-1:0]    find_pos;
    logic             find_hit;
    logic [CW-1:0]    count_q;
    logic [KEY_W-1:0] entry      [DEPTH];
    logic [KEY_W-1:0] entry_next [DEPTH];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and request handshake; flush blocks acceptance
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        bus.req_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = !bus.flush;
                if (bus.tick && bus.req_valid && !bus.flush) begin
                    accept     = 1'b1;
                    state_next = CMP;
                end
            end
            CMP:     state_next = UPD;
            UPD:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lowest valid index holding the latched key
    always_comb begin
        find_hit = 1'b0;
        find_pos = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!find_hit && (CW'(i) < count_q) && (entry[i] == key_q)) begin
                find_hit = 1'b1;
                find_pos = PW'(i);
            end
        end
    end

    // Updated list: a miss shifts everything down, a hit shifts only 0..pos
    always_comb begin
        entry_next[0] = key_q;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (!match_q || (PW'(i) <= pos_q)) entry_next[i] = entry[i-1];
            else                               entry_next[i] = entry[i];
        end
    end

    // List contents, latched access state and reported results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q         <= '0;
            pos_q         <= '0;
            match_q       <= 1'b0;
            count_q       <= '0;
            bus.done      <= 1'b0;
            bus.hit       <= 1'b0;
            bus.hit_pos   <= '0;
            bus.evicted   <= 1'b0;
            bus.evict_key <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) entry[i] <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        count_q <= '0;
                        for (int unsigned i = 0; i < DEPTH; i++) entry[i] <= '0;
                    end else if (accept) begin
                        key_q <= bus.req_key;
                    end
                end
                CMP: begin
                    match_q <= find_hit;
                    pos_q   <= find_pos;
                end
                UPD: begin
                    for (int unsigned i = 0; i < DEPTH; i++) entry[i] <= entry_next[i];
                    bus.done    <= 1'b1;
                    bus.hit     <= match_q;
                    bus.hit_pos <= match_q ? pos_q : '0;
                    if (!match_q && (count_q == CW'(DEPTH))) begin
                        bus.evicted   <= 1'b1;
                        bus.evict_key <= entry[DEPTH-1];
                    end else begin
                        bus.evicted   <= 1'b0;
                        bus.evict_key <= '0;
                    end
                    if (!match_q && (count_q != CW'(DEPTH))) count_q <= count_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Flatten list for observation
    always_comb begin
        bus.list_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++) bus.list_flat[i*KEY_W +: KEY_W] = entry[i];
    end

    assign bus.count = count_q;
endmodule

// File: tb/tb_mru_stack.sv
// Directed bench for mru_stack with a queue-based MRU reference model
// and a per-cycle compare process.
module tb_mru_stack;
    localparam int DEPTH = 4;
    localparam int KEY_W = 4;

    logic clk;
    logic rst;
    logic tick;
    logic flush;
    logic req_valid;
    logic [KEY_W-1:0] req_key;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    bit check_en = 0;

    mru_stack_if #(.DEPTH(DEPTH), .KEY_W(KEY_W)) bus ();

    assign bus.tick      = tick;
    assign bus.flush     = flush;
    assign bus.req_valid = req_valid;
    assign bus.req_key   = req_key;

    mru_stack #(.DEPTH(DEPTH), .KEY_W(KEY_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (failures so far %0d)", n_fail);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: MRU list as a queue (index 0 = most recent)
    logic [KEY_W-1:0] mq[$];
    logic [KEY_W-1:0] mkey;
    int busy;
    int exp_done, exp_hit, exp_hit_pos, exp_evicted;
    logic [KEY_W-1:0] exp_evict_key;
    int idx;

    function automatic logic [DEPTH*KEY_W-1:0] model_list();
        logic [DEPTH*KEY_W-1:0] v;
        v = '0;
        for (int i = 0; i < mq.size(); i++) v[i*KEY_W +: KEY_W] = mq[i];
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            busy = 0;
            exp_done = 0; exp_hit = 0; exp_hit_pos = 0; exp_evicted = 0;
            exp_evict_key = '0;
        end else begin
            exp_done = 0;
            if (busy != 0) begin
                busy--;
                if (busy == 0) begin
                    idx = -1;
                    for (int i = 0; i < mq.size(); i++)
                        if (idx < 0 && mq[i] == mkey) idx = i;
                    if (idx >= 0) begin
                        exp_hit = 1; exp_hit_pos = idx;
                        exp_evicted = 0; exp_evict_key = '0;
                        mq.delete(idx);
                    end else begin
                        exp_hit = 0; exp_hit_pos = 0;
                        if (mq.size() == DEPTH) begin
                            exp_evicted = 1;
                            exp_evict_key = mq[$];
                            void'(mq.pop_back());
                        end else begin
                            exp_evicted = 0;
                            exp_evict_key = '0;
                        end
                    end
                    mq.push_front(mkey);
                    exp_done = 1;
                end
            end else if (flush) begin
                mq.delete();
            end else if (tick && req_valid) begin
                busy = 2;
                mkey = req_key;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (bus.done) done_seen++;
        if (check_en) begin
            check("done",      32'(bus.done),      32'(exp_done));
            check("req_ready", 32'(bus.req_ready), 32'(busy == 0 && !flush));
            check("count",     32'(bus.count),     32'(mq.size()));
            check("list_flat", 32'(bus.list_flat), 32'(model_list()));
            check("hit",       32'(bus.hit),       32'(exp_hit));
            check("hit_pos",   32'(bus.hit_pos),   32'(exp_hit_pos));
            check("evicted",   32'(bus.evicted),   32'(exp_evicted));
            check("evict_key", 32'(bus.evict_key), 32'(exp_evict_key));
        end
    end

    task automatic access(input logic [KEY_W-1:0] k);
        int lat;
        bit got;
        @(posedge clk); #1;
        tick = 1'b1; req_valid = 1'b1; req_key = k;
        @(posedge clk); #1;
        tick = 1'b0; req_valid = 1'b0;
        lat = 0; got = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1;
                lat = c;
            end
        end
        check("latency", 32'(lat), 32'd3);
    endtask

    initial begin
        int d0;
        logic [KEY_W-1:0] fill [4];
        fill[0] = 4'd1; fill[1] = 4'd2; fill[2] = 4'd3; fill[3] = 4'd4;
        rst = 1'b1; tick = 1'b0; flush = 1'b0; req_valid = 1'b0; req_key = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_en = 1;
        @(negedge clk);
        check("reset_count", 32'(bus.count), 32'd0);
        check("reset_ready", 32'(bus.req_ready), 32'd1);
        check("reset_list",  32'(bus.list_flat), 32'd0);

        // Fill the list with four misses
        for (int i = 0; i < 4; i++) begin
            access(fill[i]);
            check("fill_hit", 32'(bus.hit), 32'd0);
            check("fill_evicted", 32'(bus.evicted), 32'd0);
        end
        check("fill_list", 32'(bus.list_flat), 32'h1234);
        check("fill_count", 32'(bus.count), 32'd4);

        // Hit in the middle, then hit at MRU
        access(4'd2);
        check("hit2_hit", 32'(bus.hit), 32'd1);
        check("hit2_pos", 32'(bus.hit_pos), 32'd2);
        check("hit2_list", 32'(bus.list_flat), 32'h1342);
        access(4'd2);
        check("hit2b_pos", 32'(bus.hit_pos), 32'd0);
        check("hit2b_list", 32'(bus.list_flat), 32'h1342);

        // Miss on a full list evicts LRU
        access(4'd7);
        check("miss7_hit", 32'(bus.hit), 32'd0);
        check("miss7_evicted", 32'(bus.evicted), 32'd1);
        check("miss7_evict_key", 32'(bus.evict_key), 32'd1);
        check("miss7_list", 32'(bus.list_flat), 32'h3427);
        check("miss7_count", 32'(bus.count), 32'd4);

        // req_valid without tick is never accepted
        @(posedge clk); #1;
        req_valid = 1'b1; req_key = 4'd5;
        d0 = done_seen;
        repeat (10) @(negedge clk);
        check("no_tick_done", 32'(done_seen - d0), 32'd0);
        check("no_tick_list", 32'(bus.list_flat), 32'h3427);

        // Ticks during CMP/UPD are ignored: one access, one done
        @(posedge clk); #1;
        tick = 1'b1; req_key = 4'd3;
        d0 = done_seen;
        @(posedge clk); #1;
        req_key = 4'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tick = 1'b0; req_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_tick_dones", 32'(done_seen - d0), 32'd1);
        check("busy_tick_list", 32'(bus.list_flat), 32'h4273);
        check("busy_tick_pos", 32'(bus.hit_pos), 32'd3);

        // Asynchronous reset while an access is in CMP
        @(posedge clk); #1;
        tick = 1'b1; req_valid = 1'b1; req_key = 4'd5;
        @(posedge clk); #1;
        tick = 1'b0; req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_list", 32'(bus.list_flat), 32'd0);
        check("arst_ready", 32'(bus.req_ready), 32'd1);
        check("arst_hit", 32'(bus.hit), 32'd0);
        check("arst_hit_pos", 32'(bus.hit_pos), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        d0 = done_seen;
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("arst_no_done", 32'(done_seen - d0), 32'd0);

        // Flush wins over a simultaneous request
        access(4'd5);
        access(4'd6);
        check("pre_flush_list", 32'(bus.list_flat), 32'h0056);
        @(posedge clk); #1;
        flush = 1'b1; tick = 1'b1; req_valid = 1'b1; req_key = 4'd8;
        d0 = done_seen;
        @(posedge clk); #1;
        flush = 1'b0; tick = 1'b0; req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_list", 32'(bus.list_flat), 32'd0);
        check("flush_no_done", 32'(done_seen - d0), 32'd0);

        check_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
